// File: rtl/dekatron_step_counter.sv
// Multi-digit BCD step counter emulating dekatron carry ripple.
// One digit changes per clock; INC/DEC/SET/CLEAR under Request/Ready.
module dekatron_step_counter #(
  parameter int D_NUM = 3,
  parameter int WIDTH = 4*D_NUM,
  parameter int STEP_WIDTH = 4,
  parameter int BOUND_MODE = 0,
  parameter logic [WIDTH-1:0] TOP_VALUE = WIDTH'(12'h255)
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Request,
  input  logic [1:0]            Op,
  input  logic [STEP_WIDTH-1:0] Steps,
  input  logic [WIDTH-1:0]      In,
  output logic                  Ready,
  output logic                  Done,
  output logic [WIDTH-1:0]      Out,
  output logic                  Zero,
  output logic                  AtTop,
  output logic                  Wrapped
);

  localparam int IDXW = (D_NUM > 1) ? $clog2(D_NUM) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(D_NUM-1);
  localparam logic [WIDTH-1:0] NINES = {D_NUM{4'h9}};
  localparam logic [WIDTH-1:0] TOP =
    (BOUND_MODE == 0) ? NINES : TOP_VALUE;

  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_CARRY,
    S_FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      out_q, out_d;
  logic [WIDTH-1:0]      in_q, in_d;
  logic [1:0]            op_q, op_d;
  logic [STEP_WIDTH-1:0] rem_q, rem_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  wrap_q, wrap_d;

  logic [WIDTH-1:0]      set_san;
  logic                  set_over;
  logic                  dec;
  logic                  at_lim;
  logic [3:0]            cur_dig;
  logic [4:0]            bumped;
  logic [4:0]            bump0;
  logic                  step_end;
  logic                  fin;

  // {roll, new_digit} for one unit step of a single BCD digit
  function automatic logic [4:0] bump(
    input logic [3:0] d,
    input logic       down
  );
    logic       roll;
    logic [3:0] nd;
    if (down) begin
      roll = (d == 4'd0);
      nd   = roll ? 4'd9 : d - 4'd1;
    end else begin
      roll = (d >= 4'd9);
      nd   = roll ? 4'd0 : d + 4'd1;
    end
    return {roll, nd};
  endfunction

  // load value: bad digits forced to 0, then clamped to top when bounded
  always_comb begin
    set_san = '0;
    for (int i = 0; i < D_NUM; i++) begin
      set_san[i*4 +: 4] =
        (in_q[i*4 +: 4] > 4'd9) ? 4'd0 : in_q[i*4 +: 4];
    end
    set_over = (BOUND_MODE != 0) && (set_san > TOP_VALUE);
  end

  // digit currently being rippled and its stepped value
  always_comb begin
    dec     = op_q[0];
    at_lim  = dec ? (out_q == '0) : (out_q == TOP);
    cur_dig = 4'd0;
    for (int i = 0; i < D_NUM; i++) begin
      if (idx_q == IDXW'(i)) cur_dig = out_q[i*4 +: 4];
    end
    bumped = bump(cur_dig, dec);
    bump0  = bump(out_q[3:0], dec);
  end

  // next-state and datapath
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    in_d     = in_q;
    op_d     = op_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    wrap_d   = wrap_q;
    done_d   = 1'b0;
    step_end = 1'b0;
    fin      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Request) begin
          op_d    = Op;
          rem_d   = Steps;
          in_d    = In;
          wrap_d  = 1'b0;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        unique case (1'b1)
          (op_q == OP_SET): begin
            out_d  = set_over ? TOP_VALUE : set_san;
            wrap_d = set_over;
            fin    = 1'b1;
          end
          (op_q == OP_CLR): begin
            out_d = '0;
            fin   = 1'b1;
          end
          (op_q[1] == 1'b0): begin
            if (rem_q == '0) begin
              fin = 1'b1;
            end else if ((BOUND_MODE == 1) && at_lim) begin
              out_d    = dec ? TOP : '0;
              wrap_d   = 1'b1;
              step_end = 1'b1;
            end else if ((BOUND_MODE == 2) && at_lim) begin
              wrap_d  = 1'b1;
              state_d = S_FINISH;
            end else begin
              out_d[3:0] = bump0[3:0];
              if (!bump0[4]) begin
                step_end = 1'b1;
              end else if (D_NUM == 1) begin
                wrap_d   = 1'b1;
                step_end = 1'b1;
              end else begin
                idx_d   = IDXW'(1);
                state_d = S_CARRY;
              end
            end
          end
          default: fin = 1'b1;
        endcase
      end
      S_CARRY: begin
        for (int i = 0; i < D_NUM; i++) begin
          if (idx_q == IDXW'(i)) out_d[i*4 +: 4] = bumped[3:0];
        end
        if (!bumped[4]) begin
          step_end = 1'b1;
        end else if (idx_q == LAST) begin
          wrap_d   = 1'b1;
          step_end = 1'b1;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_FINISH: fin = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (step_end) begin
      rem_d = rem_q - STEP_WIDTH'(1);
      if (rem_q == STEP_WIDTH'(1)) begin
        fin = 1'b1;
      end else begin
        state_d = S_STEP;
      end
    end
    if (fin) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end
  end

  // state and datapath registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      in_q    <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      in_q    <= in_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Ready   = (state_q == S_IDLE);
  assign Done    = done_q;
  assign Out     = out_q;
  assign Zero    = (out_q == '0);
  assign AtTop   = (out_q == TOP);
  assign Wrapped = wrap_q;

endmodule

// File: tb/tb_dekatron_step_counter.sv
// Bench for dekatron_step_counter: one instance per boundary mode.
// Vector table, randomized ops vs integer model, hand sequences.
module tb_dekatron_step_counter;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic             Clk;
  logic             Rst_n;
  logic [2:0]       req;
  logic [2:0][1:0]  ops;
  logic [2:0][3:0]  stp;
  logic [2:0][11:0] din;
  logic [2:0]       rdy;
  logic [2:0]       dn;
  logic [2:0][11:0] outv;
  logic [2:0]       zr;
  logic [2:0]       at;
  logic [2:0]       wr;

  int n_tests;
  int n_fail;
  int mv [3];

  dekatron_step_counter #(.BOUND_MODE(0)) u_m0 (
    .Clk(Clk), .Rst_n(Rst_n), .Request(req[0]), .Op(ops[0]),
    .Steps(stp[0]), .In(din[0]), .Ready(rdy[0]), .Done(dn[0]),
    .Out(outv[0]), .Zero(zr[0]), .AtTop(at[0]), .Wrapped(wr[0])
  );

  dekatron_step_counter #(.BOUND_MODE(1)) u_m1 (
    .Clk(Clk), .Rst_n(Rst_n), .Request(req[1]), .Op(ops[1]),
    .Steps(stp[1]), .In(din[1]), .Ready(rdy[1]), .Done(dn[1]),
    .Out(outv[1]), .Zero(zr[1]), .AtTop(at[1]), .Wrapped(wr[1])
  );

  dekatron_step_counter #(.BOUND_MODE(2)) u_m2 (
    .Clk(Clk), .Rst_n(Rst_n), .Request(req[2]), .Op(ops[2]),
    .Steps(stp[2]), .In(din[2]), .Ready(rdy[2]), .Done(dn[2]),
    .Out(outv[2]), .Zero(zr[2]), .AtTop(at[2]), .Wrapped(wr[2])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [11:0] int2bcd(input int v);
    logic [11:0] b;
    b[3:0]  = 4'((v % 10));
    b[7:4]  = 4'(((v / 10) % 10));
    b[11:8] = 4'(((v / 100) % 10));
    return b;
  endfunction

  function automatic int load_val(input logic [11:0] b);
    int v;
    int s;
    logic [11:0] x;
    x = b;
    v = 0;
    s = 1;
    for (int i = 0; i < 3; i++) begin
      if (x[3:0] <= 4'd9) v += s * int'(x[3:0]);
      x = x >> 4;
      s = s * 10;
    end
    return v;
  endfunction

  function automatic void model(
    input  int         md,
    input  int         v0,
    input  logic [1:0] o,
    input  int         st,
    input  logic [11:0] d,
    output int         v,
    output bit         w,
    output int         lat
  );
    int top;
    int t;
    int x;
    int dig;
    top = (md == 0) ? 999 : 255;
    v   = v0;
    w   = 1'b0;
    lat = 1;
    if (o == OP_SET) begin
      v = load_val(d);
      if (md != 0 && v > top) begin
        v = top;
        w = 1'b1;
      end
    end else if (o == OP_CLR) begin
      v = 0;
    end else if (st > 0) begin
      lat = 0;
      for (int k = 0; k < st; k++) begin
        if (md != 0 && ((o == OP_INC && v == top) ||
                        (o == OP_DEC && v == 0))) begin
          w = 1'b1;
          if (md == 2) begin
            lat += 2;
            break;
          end
          v = (o == OP_INC) ? 0 : top;
          lat += 1;
        end else begin
          dig = (o == OP_INC) ? 9 : 0;
          t = 0;
          x = v;
          while (t < 3 && x % 10 == dig) begin
            t++;
            x = x / 10;
          end
          lat += 1 + ((t > 2) ? 2 : t);
          if (o == OP_INC) begin
            v = (v + 1) % 1000;
            if (v == 0) w = 1'b1;
          end else begin
            v = (v + 999) % 1000;
            if (v == 999) w = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic do_op(
    input  int          m,
    input  logic [1:0]  o,
    input  int          st,
    input  logic [11:0] d,
    input  logic [11:0] eo,
    input  logic        ew,
    input  int          el,
    input  string       nm,
    output bit          sz
  );
    int n;
    sz     = 1'b0;
    req[m] = 1'b1;
    ops[m] = o;
    stp[m] = 4'(st);
    din[m] = d;
    @(posedge Clk);
    #1;
    req[m] = 1'b0;
    chk({nm, " busy"}, int'(rdy[m]), 0);
    chk({nm, " wrclr"}, int'(wr[m]), 0);
    n = 0;
    while (!dn[m] && n < 200) begin
      @(posedge Clk);
      #1;
      n++;
      if (zr[m]) sz = 1'b1;
    end
    chk({nm, " lat"}, n, el);
    chk({nm, " out"}, int'(outv[m]), int'(eo));
    chk({nm, " wrap"}, int'(wr[m]), int'(ew));
    chk({nm, " rdy"}, int'(rdy[m]), 1);
    chk({nm, " zero"}, int'(zr[m]), int'(eo == 12'h000));
    chk({nm, " top"}, int'(at[m]),
        int'(eo == ((m == 0) ? 12'h999 : 12'h255)));
    mv[m] = bcd2int(eo);
  endtask

  task automatic run_model(
    input int          m,
    input logic [1:0]  o,
    input int          st,
    input logic [11:0] d,
    input string       nm
  );
    int v;
    bit w;
    int lat;
    bit sz;
    model(m, mv[m], o, st, d, v, w, lat);
    do_op(m, o, st, d, int2bcd(v), w, lat, nm, sz);
  endtask

  typedef struct {
    int          m;
    logic [1:0]  op;
    int          st;
    logic [11:0] din;
    logic [11:0] eo;
    logic        ew;
    int          el;
  } vec_t;

  vec_t tbl [22];

  initial begin
    bit sz;
    int m;
    int r;
    logic [1:0] o;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 3; i++) mv[i] = 0;
    Rst_n = 1'b0;
    req   = '0;
    ops   = '0;
    stp   = '0;
    din   = '0;

    tbl[0]  = '{0, OP_SET, 0, 12'h123, 12'h123, 1'b0, 1};
    tbl[1]  = '{0, OP_INC, 1, 12'h000, 12'h124, 1'b0, 1};
    tbl[2]  = '{0, OP_SET, 0, 12'h999, 12'h999, 1'b0, 1};
    tbl[3]  = '{0, OP_INC, 2, 12'h000, 12'h001, 1'b1, 4};
    tbl[4]  = '{0, OP_DEC, 2, 12'h000, 12'h999, 1'b1, 4};
    tbl[5]  = '{0, OP_INC, 0, 12'h000, 12'h999, 1'b0, 1};
    tbl[6]  = '{0, OP_SET, 0, 12'h0A9, 12'h009, 1'b0, 1};
    tbl[7]  = '{0, OP_CLR, 0, 12'h555, 12'h000, 1'b0, 1};
    tbl[8]  = '{1, OP_SET, 0, 12'h254, 12'h254, 1'b0, 1};
    tbl[9]  = '{1, OP_INC, 3, 12'h000, 12'h001, 1'b1, 3};
    tbl[10] = '{1, OP_DEC, 2, 12'h000, 12'h255, 1'b1, 2};
    tbl[11] = '{1, OP_SET, 0, 12'h3A7, 12'h255, 1'b1, 1};
    tbl[12] = '{1, OP_SET, 0, 12'h100, 12'h100, 1'b0, 1};
    tbl[13] = '{1, OP_DEC, 1, 12'h000, 12'h099, 1'b0, 3};
    tbl[14] = '{1, OP_SET, 0, 12'h9FF, 12'h255, 1'b1, 1};
    tbl[15] = '{2, OP_SET, 0, 12'h253, 12'h253, 1'b0, 1};
    tbl[16] = '{2, OP_INC, 5, 12'h000, 12'h255, 1'b1, 4};
    tbl[17] = '{2, OP_SET, 0, 12'h3A7, 12'h255, 1'b1, 1};
    tbl[18] = '{2, OP_DEC, 1, 12'h000, 12'h254, 1'b0, 1};
    tbl[19] = '{2, OP_CLR, 0, 12'h000, 12'h000, 1'b0, 1};
    tbl[20] = '{2, OP_DEC, 3, 12'h000, 12'h000, 1'b1, 2};
    tbl[21] = '{2, OP_INC, 15, 12'h000, 12'h015, 1'b0, 16};

    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rst out", int'(outv[i]), 0);
      chk("rst rdy", int'(rdy[i]), 1);
      chk("rst done", int'(dn[i]), 0);
      chk("rst wrap", int'(wr[i]), 0);
      chk("rst zero", int'(zr[i]), 1);
      chk("rst top", int'(at[i]), 0);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      do_op(tbl[i].m, tbl[i].op, tbl[i].st, tbl[i].din,
            tbl[i].eo, tbl[i].ew, tbl[i].el,
            $sformatf("vec%0d", i), sz);
    end

    // zero must be visible during 999 -> 000 -> 001
    do_op(0, OP_SET, 0, 12'h999, 12'h999, 1'b0, 1, "z set", sz);
    do_op(0, OP_INC, 2, 12'h000, 12'h001, 1'b1, 4, "z inc", sz);
    chk("zero pulse", int'(sz), 1);

    // ripple 199 -> 190 -> 100 -> 200, busy request ignored
    do_op(0, OP_SET, 0, 12'h199, 12'h199, 1'b0, 1, "r set", sz);
    req[0] = 1'b1;
    ops[0] = OP_INC;
    stp[0] = 4'd1;
    @(posedge Clk);
    #1;
    ops[0] = OP_SET;
    din[0] = 12'h555;
    @(posedge Clk);
    #1;
    chk("rip e1", int'(outv[0]), 'h190);
    chk("rip e1 done", int'(dn[0]), 0);
    @(posedge Clk);
    #1;
    chk("rip e2", int'(outv[0]), 'h100);
    chk("rip e2 done", int'(dn[0]), 0);
    req[0] = 1'b0;
    @(posedge Clk);
    #1;
    chk("rip e3", int'(outv[0]), 'h200);
    chk("rip e3 done", int'(dn[0]), 1);
    chk("rip e3 rdy", int'(rdy[0]), 1);
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
    chk("busy ign", int'(outv[0]), 'h200);
    chk("busy done", int'(dn[0]), 0);
    mv[0] = 200;

    // reset while rippling
    do_op(0, OP_SET, 0, 12'h199, 12'h199, 1'b0, 1, "x set", sz);
    req[0] = 1'b1;
    ops[0] = OP_INC;
    stp[0] = 4'd1;
    @(posedge Clk);
    #1;
    req[0] = 1'b0;
    @(posedge Clk);
    #1;
    chk("x e1", int'(outv[0]), 'h190);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("x out", int'(outv[0]), 0);
    chk("x rdy", int'(rdy[0]), 1);
    chk("x done", int'(dn[0]), 0);
    chk("x zero", int'(zr[0]), 1);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    chk("x post done", int'(dn[0]), 0);
    chk("x post out", int'(outv[0]), 0);
    for (int i = 0; i < 3; i++) mv[i] = 0;
    run_model(0, OP_INC, 3, 12'h000, "x recover");

    // randomized ops against the integer model
    for (int k = 0; k < 150; k++) begin
      m = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 9));
      if (r < 4) o = OP_INC;
      else if (r < 7) o = OP_DEC;
      else if (r < 9) o = OP_SET;
      else o = OP_CLR;
      run_model(m, o, int'($urandom_range(0, 15)),
                12'($urandom_range(0, 4095)),
                $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dekatron_step_counter.md
Name: dekatron_step_counter

Overview:
- Parametrised successor to the decimal dekatron counter. Holds a D_NUM-digit BCD value and executes multi-step INC/DEC, SET and CLEAR operations under a Request/Ready handshake.
- Carry ripple is emulated one digit per Clk cycle, so software-visible timing matches the tube hardware.
- Three boundary modes are supported: natural modulo, top-limit wrap, and saturate.
- Used as the building block for IP/AP/loop counters in the DekatronPC core.

Parameters:
- D_NUM, 3, number of decimal digits.
- WIDTH, 4*D_NUM, data width; 4-bit BCD per digit, digit 0 in bits [3:0].
- STEP_WIDTH, 4, width of the Steps input.
- BOUND_MODE, 0, 0 = modulo 10^D_NUM, 1 = top-limit wrap, 2 = saturate.
- TOP_VALUE, BCD 255 (12'h255), upper limit for modes 1/2; ignored in mode 0.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  asynchronous active-low reset.
- Request  in  1  start an operation; sampled only when Ready=1.
- Op  in  2  00 INC, 01 DEC, 10 SET, 11 CLEAR.
- Steps  in  STEP_WIDTH  number of unit steps for INC/DEC.
- In  in  WIDTH  BCD load value for SET.
- Ready  out  1  idle, able to accept a Request.
- Done  out  1  one-cycle pulse when an operation completes.
- Out  out  WIDTH  current BCD value; intermediate ripple values are visible.
- Zero  out  1  Out == 0.
- AtTop  out  1  Out == top (TOP_VALUE in modes 1/2; all 9s in mode 0).
- Wrapped  out  1  a wrap or saturation occurred in the last operation; cleared on the next accept.

Behaviour:
- Reset (async, any state): Out=0, state IDLE, Ready=1, Done=0, Wrapped=0. Zero=1. AtTop reflects 0 vs top.
- States: IDLE, STEP, CARRY, FINISH.
- Accept: Request & Ready at a rising edge E0 latches Op, Steps and In. Ready=0 from E0 onward and Wrapped is cleared. Request while Ready=0 is ignored and has no queueing.
- SET:
  - Loaded at E1. Any digit >9 loads as 0.
  - In modes 1/2, a value > TOP_VALUE loads TOP_VALUE and sets Wrapped.
- CLEAR: Out=0 at E1.
- SET/CLEAR completion: state IDLE after E1, with Ready=1 and Done=1 for one cycle.
- INC/DEC with Steps=0: no change; Done/Ready at E1.
- Each unit step in state STEP updates digit 0 on one edge.
  - If digit 0 rolls (9->0 on INC, 0->9 on DEC), the state goes to CARRY.
  - CARRY updates the next digit on each subsequent edge, one digit per cycle, until a digit does not roll or the top digit has been processed.
  - Unit-step latency = 1 + number of digits the carry reaches.
  - Remaining-step counter decrements once per completed unit step. When it reaches 0, the last update edge is followed by IDLE with Ready=1 and Done=1 for that cycle.
- Mode 0: a carry/borrow out of the top digit wraps (999->000, 000->999) through normal ripple and sets Wrapped.
- Mode 1:
  - INC at Out==TOP_VALUE loads 0 in one cycle, with no ripple, and sets Wrapped.
  - DEC at Out==0 loads TOP_VALUE in one cycle and sets Wrapped.
  - Remaining steps continue after the wrap.
- Mode 2:
  - INC at TOP_VALUE or DEC at 0 leaves Out unchanged and sets Wrapped.
  - Remaining steps are discarded, and FINISH is entered; Done/Ready come on the next edge.
- Zero and AtTop are combinational from Out and may glitch-free toggle during the ripple.
- Done is registered and never asserts in the same cycle as Request acceptance.
- Mid-operation reset aborts immediately; no partial state survives.

Test Plan:
- Mode 0, Out=123, INC Steps=1 -> Out=124 after 1 edge; Done/Ready follow with total latency 1 cycle.
- Mode 0, Out=199, INC Steps=1 -> Out sequence 190, 100, 200 over E1..E3; Done in the cycle after E3.
- Mode 0, Out=999, INC Steps=2 -> ripple to 000 with Wrapped=1, then 001; Done; Zero pulsed during the op.
- Mode 1, TOP=255:
  - Out=254, INC Steps=3 -> 255, 000 (Wrapped=1), 001.
  - Then DEC Steps=2 -> 000, 255; Wrapped=1.
- Mode 2, TOP=255:
  - Out=253, INC Steps=5 -> 254, 255, then saturate; Out=255, Wrapped=1, AtTop=1.
  - SET In=12'h3A7 -> Out=255 (clamped) with Wrapped=1.
- Request during busy is ignored; Rst_n low mid-CARRY -> Out=0 and Ready=1 asynchronously, with no Done pulse.
